// File: rtl/nbj_target_predictor.sv
// Purpose : next-fetch-PC predictor for jumps: direct/CALL targets, a circular
//           return-address stack for RET, and a tagged direct-mapped BTB for JALR.
// Latency : 1 cycle, prediction registered from i_req_valid / i_flush_valid.
// Backpr. : none, a request or flush is accepted every cycle.
// Ports   : i_fire clock, rst async active-high reset;
//           i_req_*   prediction request (type, pc, direct target, return addr);
//           i_flush_* backend redirect with RAS pointer/occupancy checkpoint;
//           i_upd_*   BTB training write for resolved JALR targets;
//           o_pred_*  registered prediction; o_ras_ptr/o_ras_count RAS checkpoint.
module nbj_target_predictor #(
  parameter int ADDR_W      = 32,
  parameter int RAS_DEPTH   = 8,
  parameter int BTB_ENTRIES = 16,
  parameter int TAG_W       = 8,
  localparam int PW         = $clog2(RAS_DEPTH),
  localparam int IW         = $clog2(BTB_ENTRIES)
) (
  input  logic              i_fire,
  input  logic              rst,
  input  logic              i_req_valid,
  input  logic [2:0]        i_req_type,
  input  logic [ADDR_W-1:0] i_req_pc,
  input  logic [ADDR_W-1:0] i_req_jaddr,
  input  logic [ADDR_W-1:0] i_req_retaddr,
  input  logic              i_flush_valid,
  input  logic [ADDR_W-1:0] i_flush_pc,
  input  logic [PW-1:0]     i_flush_ras_ptr,
  input  logic [PW:0]       i_flush_ras_count,
  input  logic              i_upd_valid,
  input  logic [ADDR_W-1:0] i_upd_pc,
  input  logic [ADDR_W-1:0] i_upd_target,
  output logic              o_pred_valid,
  output logic [ADDR_W-1:0] o_pred_pc,
  output logic              o_pred_hit,
  output logic [PW-1:0]     o_ras_ptr,
  output logic [PW:0]       o_ras_count
);

  localparam logic [2:0] T_JALR = 3'd3;
  localparam logic [2:0] T_CALL = 3'd4;
  localparam logic [2:0] T_RET  = 3'd5;
  localparam logic [PW:0] DEPTH = (PW+1)'(RAS_DEPTH);

  // Return-address stack: ras_ptr_q names the current top slot.
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]     ras_ptr_q, ras_ptr_d;
  logic [PW:0]       ras_cnt_q, ras_cnt_d;
  logic              push_en;

  // Direct-mapped indirect-target buffer.
  logic              btb_vld_q [BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q [BTB_ENTRIES];
  logic [ADDR_W-1:0] btb_tgt_q [BTB_ENTRIES];

  logic              pred_valid_q, pred_valid_d;
  logic [ADDR_W-1:0] pred_pc_q, pred_pc_d;
  logic              pred_hit_q, pred_hit_d;

  logic [IW-1:0]     req_idx, upd_idx;
  logic [TAG_W-1:0]  req_tag, upd_tag;
  logic              btb_hit;
  logic [PW-1:0]     ptr_inc, ptr_dec;

  // Only the index and tag slices of the PCs take part in the lookup.
  logic              unused_pc_bits;
  assign unused_pc_bits = ^{i_req_pc, i_upd_pc};

  assign req_idx = i_req_pc[2 +: IW];
  assign req_tag = i_req_pc[2+IW +: TAG_W];
  assign upd_idx = i_upd_pc[2 +: IW];
  assign upd_tag = i_upd_pc[2+IW +: TAG_W];

  // Lookup reads the registered array, so a same-cycle update is not visible.
  assign btb_hit = btb_vld_q[req_idx] && (btb_tag_q[req_idx] == req_tag);

  // PW-bit arithmetic wraps modulo RAS_DEPTH, giving the circular overwrite.
  assign ptr_inc = ras_ptr_q + 1'b1;
  assign ptr_dec = ras_ptr_q - 1'b1;

  always_comb begin
    pred_valid_d = 1'b0;
    pred_pc_d    = '0;
    pred_hit_d   = 1'b0;
    ras_ptr_d    = ras_ptr_q;
    ras_cnt_d    = ras_cnt_q;
    push_en      = 1'b0;
    if (i_flush_valid) begin
      pred_valid_d = 1'b1;
      pred_pc_d    = i_flush_pc;
      pred_hit_d   = 1'b1;
      ras_ptr_d    = i_flush_ras_ptr;
      ras_cnt_d    = (i_flush_ras_count > DEPTH) ? DEPTH : i_flush_ras_count;
    end else if (i_req_valid) begin
      pred_valid_d = 1'b1;
      case (i_req_type)
        T_CALL: begin
          pred_pc_d  = i_req_jaddr;
          pred_hit_d = 1'b1;
          push_en    = 1'b1;
          ras_ptr_d  = ptr_inc;
          ras_cnt_d  = (ras_cnt_q == DEPTH) ? ras_cnt_q : ras_cnt_q + 1'b1;
        end
        T_RET: begin
          if (ras_cnt_q != '0) begin
            pred_pc_d  = ras_q[ras_ptr_q];
            pred_hit_d = 1'b1;
            ras_ptr_d  = ptr_dec;
            ras_cnt_d  = ras_cnt_q - 1'b1;
          end else begin
            pred_pc_d  = i_req_retaddr;
            pred_hit_d = 1'b0;
          end
        end
        T_JALR: begin
          pred_pc_d  = btb_hit ? btb_tgt_q[req_idx] : i_req_retaddr;
          pred_hit_d = btb_hit;
        end
        default: begin
          pred_pc_d  = i_req_jaddr;
          pred_hit_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge i_fire or posedge rst) begin
    if (rst) begin
      pred_valid_q <= 1'b0;
      pred_pc_q    <= '0;
      pred_hit_q   <= 1'b0;
      ras_ptr_q    <= '0;
      ras_cnt_q    <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_vld_q[i] <= 1'b0;
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
      end
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_pc_q    <= pred_pc_d;
      pred_hit_q   <= pred_hit_d;
      ras_ptr_q    <= ras_ptr_d;
      ras_cnt_q    <= ras_cnt_d;
      if (push_en) ras_q[ptr_inc] <= i_req_retaddr;
      if (i_upd_valid) begin
        btb_vld_q[upd_idx] <= 1'b1;
        btb_tag_q[upd_idx] <= upd_tag;
        btb_tgt_q[upd_idx] <= i_upd_target;
      end
    end
  end

  assign o_pred_valid = pred_valid_q;
  assign o_pred_pc    = pred_pc_q;
  assign o_pred_hit   = pred_hit_q;
  assign o_ras_ptr    = ras_ptr_q;
  assign o_ras_count  = ras_cnt_q;

endmodule

// File: tb/tb_nbj_target_predictor.sv
module tb_nbj_target_predictor;

  localparam int RAS_DEPTH   = 8;
  localparam int BTB_ENTRIES = 16;

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        hit;
    logic [3:0]  cnt;
  } exp_t;

  logic        i_fire = 1'b0;
  logic        rst;
  logic        i_req_valid;
  logic [2:0]  i_req_type;
  logic [31:0] i_req_pc, i_req_jaddr, i_req_retaddr;
  logic        i_flush_valid;
  logic [31:0] i_flush_pc;
  logic [2:0]  i_flush_ras_ptr;
  logic [3:0]  i_flush_ras_count;
  logic        i_upd_valid;
  logic [31:0] i_upd_pc, i_upd_target;
  logic        o_pred_valid;
  logic [31:0] o_pred_pc;
  logic        o_pred_hit;
  logic [2:0]  o_ras_ptr;
  logic [3:0]  o_ras_count;

  int checks = 0;
  int errors = 0;

  exp_t        sb [$];
  logic [31:0] mstk [$];
  logic        m_vld [BTB_ENTRIES];
  logic [7:0]  m_tag [BTB_ENTRIES];
  logic [31:0] m_tgt [BTB_ENTRIES];

  nbj_target_predictor #(
    .ADDR_W(32), .RAS_DEPTH(RAS_DEPTH), .BTB_ENTRIES(BTB_ENTRIES), .TAG_W(8)
  ) dut (
    .i_fire(i_fire), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_type(i_req_type), .i_req_pc(i_req_pc),
    .i_req_jaddr(i_req_jaddr), .i_req_retaddr(i_req_retaddr),
    .i_flush_valid(i_flush_valid), .i_flush_pc(i_flush_pc),
    .i_flush_ras_ptr(i_flush_ras_ptr), .i_flush_ras_count(i_flush_ras_count),
    .i_upd_valid(i_upd_valid), .i_upd_pc(i_upd_pc), .i_upd_target(i_upd_target),
    .o_pred_valid(o_pred_valid), .o_pred_pc(o_pred_pc), .o_pred_hit(o_pred_hit),
    .o_ras_ptr(o_ras_ptr), .o_ras_count(o_ras_count)
  );

  always #5 i_fire = ~i_fire;

  task automatic clear_model();
    logic [31:0] junk;
    while (mstk.size() > 0) junk = mstk.pop_front();
    sb.delete();
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      m_vld[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0;
    end
  endtask

  // Drive one request at the falling edge and queue what it must produce.
  task automatic model_req(input logic [2:0] t, input logic [31:0] pc,
                           input logic [31:0] ja, input logic [31:0] ra);
    exp_t        e;
    logic [3:0]  idx;
    logic [31:0] junk;
    @(negedge i_fire);
    i_req_valid = 1'b1; i_req_type = t; i_req_pc = pc;
    i_req_jaddr = ja; i_req_retaddr = ra;
    i_flush_valid = 1'b0; i_upd_valid = 1'b0;
    e.vld = 1'b1; e.pc = ja; e.hit = 1'b1;
    if (t == 3'd5) begin
      if (mstk.size() > 0) e.pc = mstk.pop_back();
      else begin e.pc = ra; e.hit = 1'b0; end
    end else if (t == 3'd4) begin
      mstk.push_back(ra);
      if (mstk.size() > RAS_DEPTH) junk = mstk.pop_front();
    end else if (t == 3'd3) begin
      idx = pc[5:2];
      if (m_vld[idx] && m_tag[idx] == pc[13:6]) e.pc = m_tgt[idx];
      else begin e.pc = ra; e.hit = 1'b0; end
    end
    e.cnt = 4'(mstk.size());
    sb.push_back(e);
  endtask

  // Called after model_req in the same cycle so the lookup sees old contents.
  task automatic model_upd(input logic [31:0] pc, input logic [31:0] tgt);
    i_upd_valid = 1'b1; i_upd_pc = pc; i_upd_target = tgt;
    m_vld[pc[5:2]] = 1'b1; m_tag[pc[5:2]] = pc[13:6]; m_tgt[pc[5:2]] = tgt;
  endtask

  task automatic model_idle();
    exp_t e;
    @(negedge i_fire);
    i_req_valid = 1'b0; i_flush_valid = 1'b0; i_upd_valid = 1'b0;
    e.vld = 1'b0; e.pc = '0; e.hit = 1'b0; e.cnt = 4'(mstk.size());
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge i_fire);
    i_req_valid = 1'b0; i_flush_valid = 1'b0; i_upd_valid = 1'b0;
    rst = 1'b1;
    @(negedge i_fire);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (o_pred_valid !== 1'b0 || o_pred_pc !== 32'h0 || o_pred_hit !== 1'b0 ||
        o_ras_ptr !== 3'd0 || o_ras_count !== 4'd0) begin
      errors++;
      $display("FAIL reset: got vld=%b pc=%h hit=%b ptr=%0d cnt=%0d, want all zero",
               o_pred_valid, o_pred_pc, o_pred_hit, o_ras_ptr, o_ras_count);
    end
    @(negedge i_fire);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_call_ret();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: model_req(3'd4, 32'h100, 32'h400, 32'h104);
        1: model_req(3'd5, 32'h400, 32'h0, 32'h404);
        default: model_idle();
      endcase
      @(posedge i_fire); #1;
      e = sb.pop_front();
      checks++;
      if (o_pred_valid !== e.vld || (e.vld && (o_pred_pc !== e.pc || o_pred_hit !== e.hit)) ||
          o_ras_count !== e.cnt) begin
        errors++;
        $display("FAIL call_ret step%0d: got vld=%b pc=%h hit=%b cnt=%0d, want vld=%b pc=%h hit=%b cnt=%0d",
                 s, o_pred_valid, o_pred_pc, o_pred_hit, o_ras_count, e.vld, e.pc, e.hit, e.cnt);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    for (int s = 0; s < 18; s++) begin
      if (s < 9) model_req(3'd4, 32'h1000 + s * 4, 32'h2000, 32'(s + 1) * 32'h10);
      else       model_req(3'd5, 32'h3000, 32'h0, 32'h5000 + 32'(s));
      @(posedge i_fire); #1;
      e = sb.pop_front();
      checks++;
      if (o_pred_valid !== e.vld || o_pred_pc !== e.pc || o_pred_hit !== e.hit ||
          o_ras_count !== e.cnt) begin
        errors++;
        $display("FAIL overflow step%0d: got pc=%h hit=%b cnt=%0d, want pc=%h hit=%b cnt=%0d",
                 s, o_pred_pc, o_pred_hit, o_ras_count, e.pc, e.hit, e.cnt);
      end
    end
  endtask

  task automatic test_jalr();
    exp_t e;
    for (int s = 0; s < 6; s++) begin
      case (s)
        0: model_req(3'd3, 32'h208, 32'h0, 32'h20c);
        1: begin model_idle(); model_upd(32'h208, 32'h800); end
        2: model_req(3'd3, 32'h208, 32'h0, 32'h20c);
        3: model_req(3'd3, 32'h208 + BTB_ENTRIES * 4, 32'h0, 32'h24c);
        4: begin model_req(3'd3, 32'h30c, 32'h0, 32'h310); model_upd(32'h30c, 32'h900); end
        default: model_req(3'd3, 32'h30c, 32'h0, 32'h310);
      endcase
      @(posedge i_fire); #1;
      e = sb.pop_front();
      checks++;
      if (o_pred_valid !== e.vld || (e.vld && (o_pred_pc !== e.pc || o_pred_hit !== e.hit)) ||
          o_ras_count !== e.cnt) begin
        errors++;
        $display("FAIL jalr step%0d: got vld=%b pc=%h hit=%b, want vld=%b pc=%h hit=%b",
                 s, o_pred_valid, o_pred_pc, o_pred_hit, e.vld, e.pc, e.hit);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [2:0] types [5];
    types[0] = 3'd0; types[1] = 3'd1; types[2] = 3'd2; types[3] = 3'd6; types[4] = 3'd7;
    for (int s = 0; s < 5; s++) begin
      model_req(types[s], 32'h600 + 32'(s) * 8, 32'hA000 + 32'(s) * 32'h44, 32'h604);
      @(posedge i_fire); #1;
      e = sb.pop_front();
      checks++;
      if (o_pred_valid !== e.vld || o_pred_pc !== e.pc || o_pred_hit !== e.hit ||
          o_ras_count !== e.cnt) begin
        errors++;
        $display("FAIL back_to_back type%0d: got pc=%h hit=%b cnt=%0d, want pc=%h hit=%b cnt=%0d",
                 types[s], o_pred_pc, o_pred_hit, o_ras_count, e.pc, e.hit, e.cnt);
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] fpc  [3];
    logic [2:0]  fptr [3];
    logic [3:0]  fcnt [3];
    logic [3:0]  wcnt [3];
    logic        fvld [3];
    fpc[0] = 32'h1000; fptr[0] = 3'd3; fcnt[0] = 4'd2;  wcnt[0] = 4'd2; fvld[0] = 1'b1;
    fpc[1] = 32'h0;    fptr[1] = 3'd3; fcnt[1] = 4'd2;  wcnt[1] = 4'd2; fvld[1] = 1'b0;
    fpc[2] = 32'h2468; fptr[2] = 3'd5; fcnt[2] = 4'd15; wcnt[2] = 4'd8; fvld[2] = 1'b1;
    for (int s = 0; s < 3; s++) begin
      @(negedge i_fire);
      i_upd_valid = 1'b0;
      i_req_valid = fvld[s] && (s == 0); i_req_type = 3'd4;
      i_req_pc = 32'h700; i_req_jaddr = 32'h7700; i_req_retaddr = 32'h704;
      i_flush_valid = fvld[s]; i_flush_pc = fpc[s];
      i_flush_ras_ptr = fptr[s]; i_flush_ras_count = fcnt[s];
      @(posedge i_fire); #1;
      checks++;
      if (o_pred_valid !== fvld[s] || (fvld[s] && (o_pred_pc !== fpc[s] || o_pred_hit !== 1'b1)) ||
          o_ras_ptr !== fptr[s] || o_ras_count !== wcnt[s]) begin
        errors++;
        $display("FAIL flush step%0d: got vld=%b pc=%h hit=%b ptr=%0d cnt=%0d, want vld=%b pc=%h hit=1 ptr=%0d cnt=%0d",
                 s, o_pred_valid, o_pred_pc, o_pred_hit, o_ras_ptr, o_ras_count,
                 fvld[s], fpc[s], fptr[s], wcnt[s]);
      end
    end
    pulse_reset();
  endtask

  task automatic test_async_reset();
    exp_t e;
    for (int s = 0; s < 3; s++) begin
      model_req(3'd4, 32'h800 + 32'(s) * 4, 32'h8800, 32'h804 + 32'(s) * 4);
      @(posedge i_fire); #1;
      e = sb.pop_front();
      checks++;
      if (o_pred_pc !== e.pc || o_ras_count !== e.cnt) begin
        errors++;
        $display("FAIL rst_push%0d: got pc=%h cnt=%0d, want pc=%h cnt=%0d",
                 s, o_pred_pc, o_ras_count, e.pc, e.cnt);
      end
    end
    // A CALL and a BTB update are in flight when reset hits between edges.
    @(negedge i_fire);
    i_req_valid = 1'b1; i_req_type = 3'd4; i_req_retaddr = 32'h999;
    model_upd(32'h208, 32'hBEEF);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_pred_valid !== 1'b0 || o_ras_count !== 4'd0 || o_ras_ptr !== 3'd0) begin
      errors++;
      $display("FAIL rst_async: got vld=%b cnt=%0d ptr=%0d, want vld=0 cnt=0 ptr=0",
               o_pred_valid, o_ras_count, o_ras_ptr);
    end
    @(negedge i_fire);
    i_req_valid = 1'b0; i_upd_valid = 1'b0;
    rst = 1'b0;
    clear_model();
    for (int s = 0; s < 2; s++) begin
      if (s == 0) model_req(3'd5, 32'h900, 32'h0, 32'h7770);
      else        model_req(3'd3, 32'h208, 32'h0, 32'h20c);
      @(posedge i_fire); #1;
      e = sb.pop_front();
      checks++;
      if (o_pred_valid !== 1'b1 || o_pred_pc !== e.pc || o_pred_hit !== e.hit ||
          o_ras_count !== e.cnt) begin
        errors++;
        $display("FAIL rst_after%0d: got pc=%h hit=%b cnt=%0d, want pc=%h hit=%b cnt=%0d",
                 s, o_pred_pc, o_pred_hit, o_ras_count, e.pc, e.hit, e.cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    i_req_valid = 1'b0; i_req_type = '0; i_req_pc = '0; i_req_jaddr = '0; i_req_retaddr = '0;
    i_flush_valid = 1'b0; i_flush_pc = '0; i_flush_ras_ptr = '0; i_flush_ras_count = '0;
    i_upd_valid = 1'b0; i_upd_pc = '0; i_upd_target = '0;
    clear_model();
    test_reset();
    test_call_ret();
    test_overflow();
    test_jalr();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
